ysyx_22050019_axi_sram: RTL and testbench

AXI4-Lite-style memory slave that sits directly downstream of the load/store unit's AXI master port. It provides single-beat reads and writes to an internal 64-bit-wide word array with a programmable response latency. Read and write channels are independent and each handles one transaction at a time. Its handshake timing is matched to the LSU: `aw_valid` is a single-cycle pulse, and `w_valid` follows one cycle after the AW handshake.

---
 rtl/ysyx_22050019_axi_sram_pkg.sv | 30 +++
 rtl/ysyx_22050019_axi_sram_if.sv | 40 ++++
 rtl/ysyx_22050019_axi_sram_lat_cnt.sv | 29 ++
 rtl/ysyx_22050019_axi_sram.sv | 162 ++++++++++++++++
 tb/tb_ysyx_22050019_axi_sram.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22050019_axi_sram_pkg.sv
// Shared definitions for the LSU-side AXI4-Lite SRAM slave.
//   - AXI response codes
//   - read / write channel FSM state encodings
//   - default byte address of word 0
//   - resp_of(): maps an address range flag to its response code
package ysyx_22050019_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [63:0] AXI_BASE_ADDR_DEFAULT = 64'h8000_0000;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_WAIT,
        W_RESP
    } w_state_t;

    function automatic logic [1:0] resp_of(input logic in_range);
        return in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/ysyx_22050019_axi_sram_if.sv
// Single-beat AXI4-Lite-style bus between the LSU (master) and the SRAM
// slave. Five channels: AW, W, B, AR, R.
//   master modport: drives valids/addresses/data and the B/R readies
//   slave  modport: drives AW/W/AR readies and the B/R responses
interface ysyx_22050019_axi_sram_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
);
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic                        w_valid;
    logic                        w_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        b_valid;
    logic                        b_ready;
    logic [1:0]                  b_resp;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic                        r_valid;
    logic                        r_ready;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;

    modport master (
        output aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid,
               r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid,
               r_data, r_resp
    );
endinterface

// File: rtl/ysyx_22050019_axi_sram_lat_cnt.sv
// Loadable down-counter timing the response latency of one channel.
//   clk, rst (async, active-low)
//   load : reload the counter with LATENCY
//   done : high in the cycle whose closing edge takes the count to zero
module ysyx_22050019_lat_cnt #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    // A zero-latency channel never loads a non-zero value; keep one bit.
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(LATENCY);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == CW'(1));
endmodule

// File: rtl/ysyx_22050019_axi_sram.sv
// AXI4-Lite-style SRAM slave behind the LSU master port.
//   clk, rst (async, active-low)
//   bus : slave side of ysyx_22050019_axi_sram_if (AW/W/B/AR/R)
// Independent read and write FSMs, one transaction in flight each.
// Out-of-range accesses answer SLVERR; reads then return 0, writes are
// dropped. Array contents survive reset.
module ysyx_22050019_axi_sram
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int                      AXI_DATA_WIDTH = 64,
    parameter int                      AXI_ADDR_WIDTH = 64,
    parameter int                      MEM_WORDS      = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR    = AXI_ADDR_WIDTH'(AXI_BASE_ADDR_DEFAULT),
    parameter int                      LATENCY        = 2
) (
    input logic                    clk,
    input logic                    rst,
    ysyx_22050019_axi_sram_if.slave bus
);
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int DW    = AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef struct packed {
        logic             ok;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Byte address -> word index plus range flag; addr[2:0] drops out.
    function automatic dec_t addr_dec(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        dec_t          d;
        off   = a - BASE_ADDR;
        d.ok  = (a >= BASE_ADDR) && ((off >> 3) < AW'(MEM_WORDS));
        d.idx = off[IDX_W+2:3];
        return d;
    endfunction

    logic [DW-1:0] mem [MEM_WORDS];

    // ---------------- read channel ----------------
    r_state_t      r_state, r_next;
    logic          ar_ready_q, r_valid_q;
    logic [DW-1:0] r_data_q;
    logic [1:0]    r_resp_q;
    dec_t          r_dec_q, r_dec_s;
    logic          ar_hs, r_hs, r_done, r_sample;

    assign ar_hs = bus.ar_valid && ar_ready_q;
    assign r_hs  = r_valid_q && bus.r_ready;

    ysyx_22050019_lat_cnt #(.LATENCY(LATENCY)) u_r_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (ar_hs),
        .done (r_done)
    );

    always_comb begin
        r_next   = r_state;
        r_sample = 1'b0;
        r_dec_s  = r_dec_q;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = (LATENCY == 0) ? R_DATA : R_WAIT;
            R_WAIT:  if (r_done) r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
        // Zero latency samples on the AR edge, before the address is latched.
        if (r_state == R_IDLE) r_dec_s = addr_dec(bus.ar_addr);
        r_sample = (r_next == R_DATA) && (r_state != R_DATA);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= AXI_RESP_OKAY;
            r_dec_q    <= '0;
        end else begin
            r_state    <= r_next;
            // Ready returns one cycle after the FSM is back in idle.
            ar_ready_q <= (r_state == R_IDLE) && (r_next == R_IDLE);
            r_valid_q  <= (r_next == R_DATA);
            if (ar_hs) r_dec_q <= addr_dec(bus.ar_addr);
            if (r_sample) begin
                r_data_q <= r_dec_s.ok ? mem[r_dec_s.idx] : '0;
                r_resp_q <= resp_of(r_dec_s.ok);
            end
        end
    end

    assign bus.ar_ready = ar_ready_q;
    assign bus.r_valid  = r_valid_q;
    assign bus.r_data   = r_data_q;
    assign bus.r_resp   = r_resp_q;

    // ---------------- write channel ----------------
    w_state_t   w_state, w_next;
    logic       aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0] b_resp_q;
    dec_t       w_dec_q;
    logic       aw_hs, w_hs, b_hs, w_done;

    assign aw_hs = bus.aw_valid && aw_ready_q;
    assign w_hs  = bus.w_valid && w_ready_q;
    assign b_hs  = b_valid_q && bus.b_ready;

    ysyx_22050019_lat_cnt #(.LATENCY(LATENCY)) u_w_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (w_hs),
        .done (w_done)
    );

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs) w_next = (LATENCY == 0) ? W_RESP : W_WAIT;
            W_WAIT:  if (w_done) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= AXI_RESP_OKAY;
            w_dec_q    <= '0;
        end else begin
            w_state    <= w_next;
            aw_ready_q <= (w_state == W_IDLE) && (w_next == W_IDLE);
            w_ready_q  <= (w_next == W_DATA);
            b_valid_q  <= (w_next == W_RESP);
            if (aw_hs) w_dec_q  <= addr_dec(bus.aw_addr);
            if (w_hs)  b_resp_q <= resp_of(w_dec_q.ok);
        end
    end

    // Array has no reset; w_ready_q is cleared by reset so an aborted
    // transaction cannot commit.
    always_ff @(posedge clk) begin
        if (w_hs && w_dec_q.ok) begin
            for (int i = 0; i < SW; i++) begin
                if (bus.w_strb[i]) mem[w_dec_q.idx][8*i +: 8] <= bus.w_data[8*i +: 8];
            end
        end
    end

    assign bus.aw_ready = aw_ready_q;
    assign bus.w_ready  = w_ready_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;
endmodule

// File: tb/tb_ysyx_22050019_axi_sram.sv
module tb_ysyx_22050019_axi_sram;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 0;
    localparam int          MW    = 256;
    localparam logic [63:0] BASE  = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // sel picks which DUT the shared master signals talk to (0: LAT_A, 1: LAT_B)
    logic        sel;
    logic        m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
    logic [63:0] m_aw_addr, m_ar_addr, m_w_data;
    logic [7:0]  m_w_strb;
    logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
    logic [1:0]  s_b_resp, s_r_resp;
    logic [63:0] s_r_data;

    ysyx_22050019_axi_sram_if ia ();
    ysyx_22050019_axi_sram_if ib ();

    assign ia.aw_valid = m_aw_valid & ~sel;  assign ib.aw_valid = m_aw_valid & sel;
    assign ia.w_valid  = m_w_valid  & ~sel;  assign ib.w_valid  = m_w_valid  & sel;
    assign ia.b_ready  = m_b_ready  & ~sel;  assign ib.b_ready  = m_b_ready  & sel;
    assign ia.ar_valid = m_ar_valid & ~sel;  assign ib.ar_valid = m_ar_valid & sel;
    assign ia.r_ready  = m_r_ready  & ~sel;  assign ib.r_ready  = m_r_ready  & sel;
    assign ia.aw_addr = m_aw_addr;  assign ib.aw_addr = m_aw_addr;
    assign ia.ar_addr = m_ar_addr;  assign ib.ar_addr = m_ar_addr;
    assign ia.w_data  = m_w_data;   assign ib.w_data  = m_w_data;
    assign ia.w_strb  = m_w_strb;   assign ib.w_strb  = m_w_strb;

    assign s_aw_ready = sel ? ib.aw_ready : ia.aw_ready;
    assign s_w_ready  = sel ? ib.w_ready  : ia.w_ready;
    assign s_b_valid  = sel ? ib.b_valid  : ia.b_valid;
    assign s_b_resp   = sel ? ib.b_resp   : ia.b_resp;
    assign s_ar_ready = sel ? ib.ar_ready : ia.ar_ready;
    assign s_r_valid  = sel ? ib.r_valid  : ia.r_valid;
    assign s_r_data   = sel ? ib.r_data   : ia.r_data;
    assign s_r_resp   = sel ? ib.r_resp   : ia.r_resp;

    ysyx_22050019_axi_sram #(.MEM_WORDS(MW), .LATENCY(LAT_A)) dut_a (
        .clk (clk), .rst (rst), .bus (ia)
    );
    ysyx_22050019_axi_sram #(.MEM_WORDS(MW), .LATENCY(LAT_B)) dut_b (
        .clk (clk), .rst (rst), .bus (ib)
    );

    // ---------------- reference model ----------------
    bit [63:0] mdl [2][MW];
    int n_vec = 0;
    int n_bad = 0;

    function automatic bit m_ok(input logic [63:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 64'(MW));
    endfunction

    function automatic int m_idx(input logic [63:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    function automatic int cur_lat();
        return sel ? LAT_B : LAT_A;
    endfunction

    task automatic m_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int k;
        k = sel ? 1 : 0;
        if (m_ok(a))
            for (int i = 0; i < 8; i++)
                if (s[i]) mdl[k][m_idx(a)][8*i +: 8] = d[8*i +: 8];
    endtask

    function automatic logic [63:0] m_read(input logic [63:0] a);
        int k;
        k = sel ? 1 : 0;
        return m_ok(a) ? mdl[k][m_idx(a)] : 64'd0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- transactions (all driving/sampling on negedge) ----------------
    task automatic do_write(input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int gap, input int bd);
        int n;
        n = 0;
        while (!s_aw_ready && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready_wait", s_aw_ready, 1);
        m_aw_addr  = addr;
        m_aw_valid = 1'b1;
        @(negedge clk);
        m_aw_valid = 1'b0;
        chk("aw_ready_busy", s_aw_ready, 0);
        repeat (gap) @(negedge clk);
        chk("w_ready", s_w_ready, 1);
        m_w_data  = data;
        m_w_strb  = strb;
        m_w_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) m_w_valid = 1'b0;
        end while (!s_b_valid && n < 20);
        chk("b_latency", n, cur_lat() + 1);
        chk("b_resp", s_b_resp, m_ok(addr) ? 2'b00 : 2'b10);
        m_write(addr, data, strb);
        repeat (bd) begin
            @(negedge clk);
            chk("b_hold", s_b_valid, 1);
        end
        m_b_ready = 1'b1;
        @(negedge clk);
        m_b_ready = 1'b0;
        chk("b_done", s_b_valid, 0);
        chk("aw_ready_gap", s_aw_ready, 0);
        @(negedge clk);
        chk("aw_ready_back", s_aw_ready, 1);
    endtask

    task automatic do_read(input logic [63:0] addr, input int rd, output logic [63:0] data);
        int n;
        logic [63:0] held;
        n = 0;
        while (!s_ar_ready && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready_wait", s_ar_ready, 1);
        m_ar_addr  = addr;
        m_ar_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                m_ar_valid = 1'b0;
                chk("ar_ready_busy", s_ar_ready, 0);
            end
        end while (!s_r_valid && n < 20);
        chk("r_latency", n, cur_lat() + 1);
        chk("r_data", s_r_data, m_read(addr));
        chk("r_resp", s_r_resp, m_ok(addr) ? 2'b00 : 2'b10);
        held = s_r_data;
        data = s_r_data;
        repeat (rd) begin
            @(negedge clk);
            chk("r_hold_valid", s_r_valid, 1);
            chk("r_hold_data", s_r_data, held);
        end
        m_r_ready = 1'b1;
        @(negedge clk);
        m_r_ready = 1'b0;
        chk("r_done", s_r_valid, 0);
        chk("ar_ready_gap", s_ar_ready, 0);
        @(negedge clk);
        chk("ar_ready_back", s_ar_ready, 1);
    endtask

    task automatic chk_all_idle_zero(input string tag);
        chk({tag, "_aw_ready"}, s_aw_ready, 0);
        chk({tag, "_ar_ready"}, s_ar_ready, 0);
        chk({tag, "_w_ready"},  s_w_ready,  0);
        chk({tag, "_b_valid"},  s_b_valid,  0);
        chk({tag, "_r_valid"},  s_r_valid,  0);
        chk({tag, "_r_data"},   s_r_data,   0);
        chk({tag, "_b_resp"},   s_b_resp,   0);
        chk({tag, "_r_resp"},   s_r_resp,   0);
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        logic [63:0] a;
        r = $urandom_range(0, 9);
        if (r == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
        else if (r == 1) a = BASE + 64'(8 * MW) + 64'(8 * $urandom_range(0, 3));
        else             a = BASE + 64'(8 * $urandom_range(0, MW - 1));
        return a + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        int n;
        sel = 1'b0;
        m_aw_valid = 0; m_w_valid = 0; m_b_ready = 0; m_ar_valid = 0; m_r_ready = 0;
        m_aw_addr = 0; m_ar_addr = 0; m_w_data = 0; m_w_strb = 0;

        // reset and first ready
        #2 rst = 1'b0;
        @(negedge clk);
        chk_all_idle_zero("rst_a");
        sel = 1'b1; #1;
        chk_all_idle_zero("rst_b");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ar_ready", s_ar_ready, 1);
        chk("rel_aw_ready", s_aw_ready, 1);

        // fill the array so every word has a known value
        for (int i = 0; i < MW; i++)
            do_write(BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, 0, 0);

        // write / read / byte strobe
        do_write(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
        do_read(64'h8000_0014, 0, d);
        chk("dir_word", d, 64'h1122_3344_5566_7788);
        do_write(64'h8000_0010, 64'hAB00_0000_0000_0000, 8'h80, 0, 0);
        do_read(64'h8000_0010, 0, d);
        chk("dir_strb", d, 64'hAB22_3344_5566_7788);

        // out of range (the top one aliases word 0 if the range check is lost)
        do_read(64'h7FFF_FFF8, 0, d);
        chk("oor_rdata", d, 64'd0);
        do_write(BASE + 64'(8 * MW), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0);
        do_write(64'h7FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0, 0);
        do_read(BASE, 0, d);
        do_read(BASE + 64'(8 * (MW - 1)), 0, d);

        // backpressure, late W after AW pulse, zero strobe
        do_read(64'h8000_0010, 5, d);
        do_write(64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'h3C, 4, 3);
        do_read(64'h8000_0020, 0, d);
        do_write(64'h8000_0028, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1, 0);
        do_read(64'h8000_0028, 0, d);

        // reset while a read response is pending
        m_ar_addr = 64'h8000_0010; m_ar_valid = 1'b1;
        @(negedge clk);
        m_ar_valid = 1'b0;
        n = 0;
        while (!s_r_valid && n < 20) begin @(negedge clk); n++; end
        chk("pre_rst_r_valid", s_r_valid, 1);
        #2 rst = 1'b0;
        #1 chk_all_idle_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel2_ar_ready", s_ar_ready, 1);
        chk("rel2_aw_ready", s_aw_ready, 1);

        // reset between AW and the W edge must not write
        m_aw_addr = 64'h8000_0030; m_aw_valid = 1'b1;
        @(negedge clk);
        m_aw_valid = 1'b0;
        m_w_data = 64'h5555_AAAA_5555_AAAA; m_w_strb = 8'hFF; m_w_valid = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        m_w_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_read(64'h8000_0030, 0, d);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(rand_addr(), $urandom_range(0, 3), d);
        end

        // zero-latency instance: simultaneous AR and AW to one word
        sel = 1'b1;
        #1;
        do_write(64'h8000_0040, 64'hCAFE_0000_1111_2222, 8'hFF, 0, 0);
        n = 0;
        while (!(s_ar_ready && s_aw_ready) && n < 50) begin @(negedge clk); n++; end
        chk("cc_ready", s_ar_ready && s_aw_ready, 1);
        m_ar_addr = 64'h8000_0040; m_aw_addr = 64'h8000_0040;
        m_ar_valid = 1'b1; m_aw_valid = 1'b1;
        @(negedge clk);
        m_ar_valid = 1'b0; m_aw_valid = 1'b0;
        chk("cc_ar_busy", s_ar_ready, 0);
        chk("cc_aw_busy", s_aw_ready, 0);
        chk("cc_r_valid", s_r_valid, 1);
        chk("cc_r_old", s_r_data, m_read(64'h8000_0040));
        m_w_data = 64'h0BAD_F00D_3333_4444; m_w_strb = 8'hFF; m_w_valid = 1'b1;
        @(negedge clk);
        m_w_valid = 1'b0;
        chk("cc_b_valid", s_b_valid, 1);
        chk("cc_b_resp", s_b_resp, 2'b00);
        chk("cc_r_still_old", s_r_data, m_read(64'h8000_0040));
        m_write(64'h8000_0040, 64'h0BAD_F00D_3333_4444, 8'hFF);
        m_r_ready = 1'b1; m_b_ready = 1'b1;
        @(negedge clk);
        m_r_ready = 1'b0; m_b_ready = 1'b0;
        chk("cc_r_done", s_r_valid, 0);
        chk("cc_b_done", s_b_valid, 0);
        do_read(64'h8000_0040, 0, d);
        chk("cc_new", d, 64'h0BAD_F00D_3333_4444);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
